imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001: Parameter n_bits, default 32, instruction word width in bits (fixed to 4 bytes).
REQ-002: Parameter ADDR_W, default 8, instruction memory address width (256 words).
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst_n  input  1  reset, synchronous, active-low.
REQ-005: start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-006: len  input  ADDR_W+1  number of words to load, sampled with start.
REQ-007: abort  input  1  cancel an in-progress load.
REQ-008: byte_in  input  8  incoming program byte.
REQ-009: byte_valid  input  1  byte_in valid this cycle.
REQ-010: byte_ready  output  1  loader accepts byte_in this cycle.
REQ-011: we  output  1  instruction memory write strobe.
REQ-012: waddr  output  ADDR_W  word address for the write.
REQ-013: wdata  output  n_bits  instruction word to write.
REQ-014: busy  output  1  load in progress.
REQ-015: cpu_hold  output  1  hold processor PC/fetch while high.
REQ-016: done  output  1  one-cycle pulse on successful completion.
REQ-017: err  output  1  sticky error flag, cleared by next accepted start or reset.

Function
REQ-018: The loader SHALL implement states IDLE, RECV, WRITE, DONE.
REQ-019: A byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1.
REQ-020: byte_ready SHALL be 1 only in RECV.
REQ-021: Bytes SHALL be assembled big-endian: 1st byte -> bits 31:24, 2nd -> 23:16, 3rd -> 15:8, 4th -> 7:0.
REQ-022: IDLE + start, with 1 <= len <= 2^ADDR_W: capture len, clear word address to 0, clear byte counter, clear err, go to RECV next cycle.
REQ-023: IDLE + start with len=0: go directly to DONE; no write occurs.
REQ-024: IDLE + start with len > 2^ADDR_W: set err, stay IDLE; no write occurs.
REQ-025: RECV: on acceptance of the 4th byte of a word, go to WRITE next cycle.
REQ-026: WRITE SHALL last exactly one cycle with we=1, waddr = current word address, wdata = assembled word; we SHALL be 0 in every other state.
REQ-027: After WRITE, word address SHALL increment by 1; if words written equals len, go to DONE, else return to RECV.
REQ-028: Latency: we rises the cycle after the 4th byte is accepted.
REQ-029: waddr SHALL never wrap; the final write for len = 2^ADDR_W SHALL be at address 2^ADDR_W - 1.
REQ-030: DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-031: busy SHALL be 1 in RECV, WRITE and DONE; cpu_hold SHALL equal busy.
REQ-032: abort in RECV or WRITE SHALL take priority over all other events: go to IDLE next cycle, set err, no write that cycle, no done pulse; already-written words are not rolled back.
REQ-033: abort in IDLE or DONE SHALL be ignored.
REQ-034: start while not IDLE SHALL be ignored.
REQ-035: Partial word bytes (fewer than 4) SHALL never be written.
REQ-036: wdata and waddr SHALL hold their last values when we=0.

Reset
REQ-037: rst_n=0 at a rising edge SHALL force IDLE, byte counter 0, word address 0, assembled word 0.
REQ-038: Reset values: byte_ready=0, we=0, waddr=0, wdata=0, busy=0, cpu_hold=0, done=0, err=0.
REQ-039: Reset mid-load SHALL abandon the load with no further write and no done pulse.

Verification
REQ-040: start, len=2, bytes 00 00 80 20 20 10 00 78 back-to-back -> we at addr 0 wdata 32'h00008020, we at addr 1 wdata 32'h20100078, one done pulse, busy low after.
REQ-041: len=1, byte_valid toggling with gaps between bytes 12 11 00 06 -> single write addr 0 data 32'h12110006, exactly 4 acceptances, byte_ready=0 during WRITE.
REQ-042: len=3, abort after 6 bytes -> writes only addr 0, err=1, no done, IDLE next cycle, busy=0.
REQ-043: start with len=0 -> done pulse 1 cycle later, no we; start with len=257 -> err=1, no busy, no we.
REQ-044: len=256 with incrementing data -> 256 writes, last waddr 8'hFF, done once, no wrap to 0.
REQ-045: rst_n=0 after 2 bytes of a word, then new load len=1 -> first write uses only post-reset bytes, addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: assembles big-endian byte stream into instruction words and writes them to imem
module imem_loader #(
    parameter int n_bits = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [n_bits-1:0] wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    localparam logic [ADDR_W:0] max_len = {1'b1, {ADDR_W{1'b0}}};
    state_t state;
    logic [ADDR_W:0] len_r, addr, next_addr;
    logic [1:0] bc;
    logic [n_bits-1:0] sh, word;
    assign next_addr = addr + 1'b1;
    assign word = {sh[n_bits-9:0], byte_in};
    assign byte_ready = state == RECV;
    // abort squashes the strobe in the same cycle it arrives
    assign we = state == WRITE && !abort;
    assign busy = state != IDLE;
    assign cpu_hold = busy;
    assign done = state == DONE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            len_r <= '0;
            addr <= '0;
            bc <= '0;
            sh <= '0;
            waddr <= '0;
            wdata <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    err <= len > max_len;
                    len_r <= len;
                    addr <= '0;
                    bc <= '0;
                    state <= len == '0 ? DONE : len > max_len ? IDLE : RECV;
                end
                RECV: if (abort) begin
                    state <= IDLE;
                    err <= 1'b1;
                end else if (byte_valid) begin
                    sh <= word;
                    bc <= bc + 2'd1;
                    if (bc == 2'd3) begin
                        wdata <= word;
                        waddr <= addr[ADDR_W-1:0];
                        state <= WRITE;
                    end
                end
                WRITE: if (abort) begin
                    state <= IDLE;
                    err <= 1'b1;
                end else begin
                    addr <= next_addr;
                    state <= next_addr == len_r ? DONE : RECV;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: transaction-level model check of imem_loader with directed and random stimulus
module tb_imem_loader;
    logic clk = 0, rst_n = 0, start = 0, abort = 0, byte_valid = 0;
    logic [8:0] len = 0;
    logic [7:0] byte_in = 0;
    logic byte_ready, we, busy, cpu_hold, done, err;
    logic [7:0] waddr;
    logic [31:0] wdata;
    int checks = 0, failures = 0, done_cnt = 0, acc_cnt = 0;
    bit armed = 0;
    logic [7:0] wa_log[$];
    logic [31:0] wd_log[$];
    bit m_act = 0, m_wr = 0, m_done = 0, m_err = 0;
    int m_len = 0, m_addr = 0;
    logic [7:0] q[$];
    logic [31:0] m_word = 0;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .cpu_hold(cpu_hold),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endfunction

    function automatic void timeout(string n);
        checks++;
        failures++;
        $display("FAIL %s timed out", n);
    endfunction

    // Compare against the transaction model, then advance it by what the next edge does
    always @(negedge clk) begin
        if (armed) begin
            chk("byte_ready", byte_ready, m_act && !m_wr);
            chk("we", we, m_wr && !abort);
            chk("busy", busy, m_act || m_done);
            chk("cpu_hold", cpu_hold, m_act || m_done);
            chk("done", done, m_done);
            chk("err", err, m_err);
            if (m_wr && !abort) begin
                chk("waddr", waddr, m_addr);
                chk("wdata", wdata, m_word);
            end
            if (we) begin
                wa_log.push_back(waddr);
                wd_log.push_back(wdata);
            end
            if (done) done_cnt++;
            if (byte_valid && byte_ready) acc_cnt++;
        end
        if (!rst_n) begin
            m_act = 0; m_wr = 0; m_done = 0; m_err = 0; q.delete();
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_act) begin
            if (start) begin
                m_err = int'(len) > 256;
                if (len == 0) m_done = 1;
                else if (!m_err) begin
                    m_act = 1; m_len = int'(len); m_addr = 0; q.delete();
                end
            end
        end else if (abort) begin
            m_act = 0; m_wr = 0; m_err = 1;
        end else if (m_wr) begin
            m_wr = 0;
            m_addr++;
            if (m_addr == m_len) begin
                m_act = 0; m_done = 1;
            end
        end else if (byte_valid) begin
            q.push_back(byte_in);
            if (q.size() == 4) begin
                m_word = {q[0], q[1], q[2], q[3]};
                q.delete();
                m_wr = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int l);
        start = 1;
        len = l[8:0];
        tick();
        start = 0;
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        bit acc = 0;
        int t = 0;
        if (gaps) repeat ($urandom_range(1, 3)) begin
            byte_valid = 0;
            byte_in = 8'($urandom);
            tick();
        end
        byte_valid = 1;
        byte_in = b;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = byte_ready;
            tick();
            t++;
        end
        byte_valid = 0;
        if (!acc) timeout("send");
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (busy) timeout("wait_idle");
        tick();
    endtask

    task automatic clear_logs();
        wa_log.delete();
        wd_log.delete();
        done_cnt = 0;
        acc_cnt = 0;
    endtask

    initial begin
        int bad, d0;
        logic [7:0] b40[8] = '{8'h00, 8'h00, 8'h80, 8'h20, 8'h20, 8'h10, 8'h00, 8'h78};
        logic [7:0] b41[4] = '{8'h12, 8'h11, 8'h00, 8'h06};
        tick();
        armed = 1;
        tick();
        @(negedge clk);
        chk("rst_outs", {byte_ready, we, busy, cpu_hold, done, err}, 6'b0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        tick();
        rst_n = 1;
        tick();

        clear_logs();
        go(2);
        foreach (b40[i]) send(b40[i], 0);
        wait_idle();
        chk("r40_nwr", wa_log.size(), 2);
        if (wa_log.size() == 2) begin
            chk("r40_a0", wa_log[0], 0);
            chk("r40_d0", wd_log[0], 32'h00008020);
            chk("r40_a1", wa_log[1], 1);
            chk("r40_d1", wd_log[1], 32'h20100078);
        end
        chk("r40_done", done_cnt, 1);
        chk("r40_busy", busy, 0);

        clear_logs();
        go(1);
        foreach (b41[i]) send(b41[i], 1);
        wait_idle();
        chk("r41_nwr", wa_log.size(), 1);
        if (wa_log.size() == 1) begin
            chk("r41_a0", wa_log[0], 0);
            chk("r41_d0", wd_log[0], 32'h12110006);
        end
        chk("r41_acc", acc_cnt, 4);

        clear_logs();
        go(3);
        for (int i = 1; i <= 6; i++) send(8'(i), 0);
        abort = 1;
        tick();
        abort = 0;
        @(negedge clk);
        chk("r42_busy", busy, 0);
        chk("r42_err", err, 1);
        chk("r42_nwr", wa_log.size(), 1);
        if (wa_log.size() == 1) chk("r42_d0", wd_log[0], 32'h01020304);
        chk("r42_done", done_cnt, 0);
        tick();

        clear_logs();
        go(0);
        @(negedge clk);
        chk("r43_done", done, 1);
        chk("r43_err0", err, 0);
        tick();
        go(257);
        @(negedge clk);
        chk("r43_err", err, 1);
        chk("r43_busy", busy, 0);
        tick();
        chk("r43_nwr", wa_log.size(), 0);
        chk("r43_dcnt", done_cnt, 1);

        clear_logs();
        go(256);
        for (int k = 0; k < 1024; k++) send(8'(k), 0);
        wait_idle();
        chk("r44_nwr", wa_log.size(), 256);
        bad = 0;
        foreach (wa_log[i]) if (int'(wa_log[i]) != i) bad++;
        chk("r44_seq", bad, 0);
        if (wa_log.size() == 256) begin
            chk("r44_last_a", wa_log[255], 8'hFF);
            chk("r44_last_d", wd_log[255], 32'hFCFDFEFF);
        end
        chk("r44_done", done_cnt, 1);
        chk("r44_err", err, 0);

        clear_logs();
        go(1);
        send(8'h55, 0);
        send(8'h66, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        go(1);
        send(8'hAA, 0);
        send(8'hBB, 0);
        send(8'hCC, 0);
        send(8'hDD, 0);
        wait_idle();
        chk("r45_nwr", wa_log.size(), 1);
        if (wa_log.size() == 1) begin
            chk("r45_a0", wa_log[0], 0);
            chk("r45_d0", wd_log[0], 32'hAABBCCDD);
        end
        chk("r45_done", done_cnt, 1);

        clear_logs();
        for (int c = 0; c < 4000; c++) begin
            int r = $urandom_range(0, 9);
            start = $urandom_range(0, 19) == 0;
            len = r == 0 ? 9'd0 : r == 1 ? 9'(257 + $urandom_range(0, 254)) : 9'($urandom_range(1, 6));
            abort = $urandom_range(0, 49) == 0;
            byte_valid = $urandom_range(0, 2) != 0;
            byte_in = 8'($urandom);
            rst_n = $urandom_range(0, 299) != 0;
            tick();
        end
        start = 0;
        abort = 0;
        byte_valid = 0;
        rst_n = 1;
        d0 = done_cnt;
        wait_idle();
        chk("rand_activity", wa_log.size() > 20, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
